axi_rd_mem_responder: RTL and testbench
=======================================

// Module: axi_rd_mem_responder
// PURPOSE
// - AXI4 read-channel responder (slave) serving the CVA6 AXI master's reads of one address region.
// - Typical use: the boot ROM window at 64'h1_0000, length 64'h10000.
// - Decodes AR bursts, drives a 1-cycle-latency synchronous memory read port and returns R beats.
// - Sits on the testbench/SoC side of the core AXI port; no write channels.
// PARAMETERS
// - AxiIdWidth    4         : ARID/RID width.
// - AxiAddrWidth  64        : ARADDR width.
// - AxiDataWidth  64        : RDATA width; power of 2, >= 32.
// - RegionBase    64'h1_0000 : first byte address served.
// - RegionLength  64'h10000  : region size in bytes; power of 2, multiple of AxiDataWidth/8.
// - MemAddrWidth  $clog2(RegionLength/(AxiDataWidth/8)) : word index width.
// PORTS
// - clk_i           in   1             : clock.
// - rst_i           in   1             : synchronous reset, active high.
// - ar_valid_i      in   1             : AR valid.
// - ar_ready_o      out  1             : AR ready.
// - ar_id_i         in   AxiIdWidth    : ARID.
// - ar_addr_i       in   AxiAddrWidth  : ARADDR.
// - ar_len_i        in   8             : ARLEN (beats - 1).
// - ar_size_i       in   3             : ARSIZE.
// - ar_burst_i      in   2             : ARBURST.
// - r_valid_o       out  1             : R valid.
// - r_ready_i       in   1             : R ready.
// - r_id_o          out  AxiIdWidth    : RID.
// - r_data_o        out  AxiDataWidth  : RDATA.
// - r_resp_o        out  2             : RRESP; 2'b00 OKAY, 2'b10 SLVERR.
// - r_last_o        out  1             : RLAST.
// - mem_req_o       out  1             : memory read strobe.
// - mem_addr_o      out  MemAddrWidth  : word index, (beat_addr - RegionBase) >> log2(AxiDataWidth/8).
// - mem_rdata_i     in   AxiDataWidth  : read data, valid the cycle after mem_req_o.
// BEHAVIOUR
// - Reset values: ar_ready_o=1, r_valid_o=0, r_last_o=0, r_resp_o=0, r_id_o=0, r_data_o=0, mem_req_o=0.
// - States:
//   - IDLE: ar_ready_o=1. On AR handshake, latch id/addr/len/size/burst and error flag, then go to FETCH.
//   - FETCH: 1 cycle. mem_req_o=1 only if the beat is in range and the burst is legal. Then go to RESP.
//   - RESP: capture mem_rdata_i, or 0 on error. Hold r_valid_o=1 and stable R fields until r_ready_i.
//     - On R handshake, if it was the last beat go to IDLE, else advance the beat address and go to FETCH.
// - Latency: AR handshake in cycle 0 -> mem_req_o in cycle 1 -> r_valid_o in cycle 2. Throughput is 1 beat per 2 cycles.
// - ar_ready_o=0 outside IDLE. Only one burst is outstanding at a time.
// - r_id_o equals the latched ARID for every beat. r_last_o=1 only on beat ar_len_i.
// - Beat address, with bytes = 2**size:
//   - FIXED (2'b00): constant.
//   - INCR (2'b01): beat 0 uses ARADDR. Each later beat is the previous one aligned down to size, plus bytes.
//   - WRAP (2'b10): wrap window is (len+1)*bytes, aligned. The address increments and wraps to the window base.
// - Illegal bursts answer every beat with SLVERR and rdata 0; the beat count is still honoured:
//   - ar_size_i > log2(AxiDataWidth/8);
//   - ar_burst_i == 2'b11;
//   - WRAP with len not in {1,3,7,15};
//   - WRAP with ARADDR unaligned to size.
// - Range check is per beat: beat_addr outside [RegionBase, RegionBase+RegionLength) gives SLVERR, rdata 0 and no mem_req_o.
// - Narrow transfers return the full memory word; the master selects the byte lanes.
// - Address arithmetic is AxiAddrWidth wide. No 4 KiB boundary check is made, since crossing is a master protocol violation.
// - Reset mid-burst: the next cycle is IDLE with r_valid_o=0. The burst is abandoned and no further beats are issued.
// - Reset has priority over every handshake in the same cycle.
// TESTING
// - Single beat: ARADDR=0x1_0008, len=0, size=3, INCR, id=5.
//   -> mem_addr_o=1; one beat with RID=5, RLAST=1, OKAY, data=mem[1], r_valid_o in cycle 2.
// - INCR: ARADDR=0x1_0010, len=3, size=3.
//   -> mem_addr_o 2,3,4,5; RLAST on the 4th beat only; all OKAY.
// - WRAP: ARADDR=0x1_0018, len=3, size=3.
//   -> mem_addr_o 3,0,1,2 (window 0x1_0000..0x1_001F).
// - Out of range: ARADDR=0x1_FFF8, len=1, INCR.
//   -> beat 0 OKAY with mem[0x1FFF]; beat 1 SLVERR, data 0, no mem_req_o.
// - Backpressure: hold r_ready_i=0 for 5 cycles during beat 1 of a len=2 burst.
//   -> R fields stable, no extra mem_req_o, no beat lost or duplicated.
// - Illegal burst and reset:
//   - size=4 with a 64-bit bus, len=2 -> 3 SLVERR beats, zero data, no mem_req_o.
//   - rst_i asserted during RESP -> r_valid_o=0 next cycle, ar_ready_o=1.

Source files
------------

// File: rtl/axi_rd_mem_responder.sv
// rtl/axi_rd_mem_responder.sv - AXI4 read responder for one address region, 1-cycle sync memory port
module axi_rd_mem_responder #(
  parameter int          AxiIdWidth   = 4,
  parameter int          AxiAddrWidth = 64,
  parameter int          AxiDataWidth = 64,
  parameter logic [63:0] RegionBase   = 64'h1_0000,
  parameter logic [63:0] RegionLength = 64'h10000,
  parameter int          MemAddrWidth = $clog2(RegionLength / (AxiDataWidth / 8))
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    ar_valid_i,
  output logic                    ar_ready_o,
  input  logic [AxiIdWidth-1:0]   ar_id_i,
  input  logic [AxiAddrWidth-1:0] ar_addr_i,
  input  logic [7:0]              ar_len_i,
  input  logic [2:0]              ar_size_i,
  input  logic [1:0]              ar_burst_i,
  output logic                    r_valid_o,
  input  logic                    r_ready_i,
  output logic [AxiIdWidth-1:0]   r_id_o,
  output logic [AxiDataWidth-1:0] r_data_o,
  output logic [1:0]              r_resp_o,
  output logic                    r_last_o,
  output logic                    mem_req_o,
  output logic [MemAddrWidth-1:0] mem_addr_o,
  input  logic [AxiDataWidth-1:0] mem_rdata_i
);

  localparam int                      OffBits = $clog2(AxiDataWidth / 8);
  localparam logic [2:0]              MaxSize = 3'(OffBits);
  localparam logic [AxiAddrWidth-1:0] BaseA   = AxiAddrWidth'(RegionBase);
  localparam logic [AxiAddrWidth-1:0] EndA    = AxiAddrWidth'(RegionBase + RegionLength);

  typedef enum logic [1:0] {IDLE, FETCH, RESP} state_e;
  state_e state_q, state_d;

  logic [AxiIdWidth-1:0]   id_q;
  logic [AxiAddrWidth-1:0] addr_q;
  logic [7:0]              len_q;
  logic [2:0]              size_q;
  logic [1:0]              burst_q;
  logic                    err_q;
  logic [7:0]              cnt_q;
  logic [1:0]              resp_q;
  logic                    last_q;
  logic                    beat_err_q;
  logic                    first_q;
  logic [AxiDataWidth-1:0] data_q;

  logic                    ar_hs, r_hs, in_range, ar_err, wrap_len_ok;
  logic [AxiAddrWidth-1:0] ar_mask, bytes, wsize, next_addr;

  assign ar_ready_o = (state_q == IDLE);
  assign r_valid_o  = (state_q == RESP);
  assign ar_hs      = ar_valid_i && ar_ready_o;
  assign r_hs       = r_valid_o && r_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ar_hs) state_d = FETCH;
      FETCH:   state_d = RESP;
      RESP:    if (r_hs) state_d = last_q ? IDLE : FETCH;
      default: state_d = IDLE;
    endcase
  end

  // Burst legality is decided once at AR time; the range check is redone every beat.
  assign ar_mask     = (AxiAddrWidth'(1) << ar_size_i) - AxiAddrWidth'(1);
  assign wrap_len_ok = (ar_len_i == 8'd1) || (ar_len_i == 8'd3) ||
                       (ar_len_i == 8'd7) || (ar_len_i == 8'd15);
  assign ar_err      = (ar_size_i > MaxSize) || (ar_burst_i == 2'b11) ||
                       ((ar_burst_i == 2'b10) && (!wrap_len_ok || ((ar_addr_i & ar_mask) != '0)));

  assign in_range   = (addr_q >= BaseA) && (addr_q < EndA);
  assign mem_req_o  = (state_q == FETCH) && !err_q && in_range;
  assign mem_addr_o = MemAddrWidth'((addr_q - BaseA) >> OffBits);

  assign bytes = AxiAddrWidth'(1) << size_q;
  assign wsize = (AxiAddrWidth'(len_q) + AxiAddrWidth'(1)) << size_q;

  always_comb begin
    next_addr = (addr_q & ~(bytes - AxiAddrWidth'(1))) + bytes;
    case (burst_q)
      2'b00:   next_addr = addr_q;
      2'b10:   next_addr = (addr_q & ~(wsize - AxiAddrWidth'(1))) |
                           ((addr_q + bytes) & (wsize - AxiAddrWidth'(1)));
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      resp_q     <= '0;
      last_q     <= 1'b0;
      beat_err_q <= 1'b0;
      first_q    <= 1'b0;
      data_q     <= '0;
    end else begin
      first_q <= 1'b0;
      if (ar_hs) begin
        id_q    <= ar_id_i;
        addr_q  <= ar_addr_i;
        len_q   <= ar_len_i;
        size_q  <= ar_size_i;
        burst_q <= ar_burst_i;
        err_q   <= ar_err;
        cnt_q   <= '0;
      end
      if (state_q == FETCH) begin
        beat_err_q <= err_q || !in_range;
        resp_q     <= (err_q || !in_range) ? 2'b10 : 2'b00;
        last_q     <= (cnt_q == len_q);
        first_q    <= 1'b1;
      end
      if ((state_q == RESP) && first_q)
        data_q <= beat_err_q ? '0 : mem_rdata_i;
      if (r_hs && !last_q) begin
        addr_q <= next_addr;
        cnt_q  <= cnt_q + 8'd1;
      end
    end
  end

  // Memory data is only valid in the first RESP cycle; later cycles replay the captured copy.
  assign r_data_o = first_q ? (beat_err_q ? '0 : mem_rdata_i) : data_q;
  assign r_id_o   = id_q;
  assign r_resp_o = resp_q;
  assign r_last_o = last_q;

endmodule

// File: tb/tb_axi_rd_mem_responder.sv
// tb/tb_axi_rd_mem_responder.sv - directed self-checking bench for axi_rd_mem_responder
module tb_axi_rd_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        ar_valid, ar_ready;
  logic [3:0]  ar_id;
  logic [63:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic        r_valid, r_ready;
  logic [3:0]  r_id;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic        mem_req;
  logic [12:0] mem_addr;
  logic [63:0] mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  axi_rd_mem_responder dut (
    .clk_i(clk), .rst_i(rst),
    .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_id_i(ar_id), .ar_addr_i(ar_addr),
    .ar_len_i(ar_len), .ar_size_i(ar_size), .ar_burst_i(ar_burst),
    .r_valid_o(r_valid), .r_ready_i(r_ready), .r_id_o(r_id), .r_data_o(r_data),
    .r_resp_o(r_resp), .r_last_o(r_last),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] memf(input int idx);
    logic [15:0] s;
    s = idx[15:0];
    return {16'hC0DE, s, ~s, 16'h5A5A ^ s};
  endfunction

  // Read data only valid after a request; junk otherwise so stale sampling shows up.
  always @(posedge clk) mem_rdata <= mem_req ? memf(int'(mem_addr)) : 64'hBAD0_BAD0_BAD0_BAD0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    ar_valid = 1'b1; ar_id = id; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst;
    @(negedge clk);
    chk("ar_ready_idle", ar_ready, 1);
    @(posedge clk); #1;
    ar_valid = 1'b0;
  endtask

  task automatic beat(input bit exp_req, input int exp_idx, input logic [63:0] exp_data,
                      input logic [1:0] exp_resp, input bit exp_last, input logic [3:0] exp_id,
                      input int hold);
    @(negedge clk);
    chk("fetch_req", mem_req, exp_req);
    if (exp_req) chk("fetch_addr", mem_addr, exp_idx);
    chk("fetch_rvalid", r_valid, 0);
    chk("fetch_arready", ar_ready, 0);
    @(posedge clk); #1;
    r_ready = (hold == 0);
    @(negedge clk);
    chk("r_valid", r_valid, 1);
    chk("r_id", r_id, exp_id);
    chk("r_data", r_data, exp_data);
    chk("r_resp", r_resp, exp_resp);
    chk("r_last", r_last, exp_last);
    chk("resp_req", mem_req, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      chk("hold_valid", r_valid, 1);
      chk("hold_data", r_data, exp_data);
      chk("hold_last", r_last, exp_last);
      chk("hold_resp", r_resp, exp_resp);
      chk("hold_req", mem_req, 0);
    end
    r_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; ar_valid = 1'b0; ar_id = '0; ar_addr = '0; ar_len = '0; ar_size = '0;
    ar_burst = '0; r_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ar_ready", ar_ready, 1);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_r_last", r_last, 0);
    chk("rst_r_resp", r_resp, 0);
    chk("rst_r_id", r_id, 0);
    chk("rst_r_data", r_data, 0);
    chk("rst_mem_req", mem_req, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single beat
    send_ar(4'd5, 64'h1_0008, 8'd0, 3'd3, 2'b01);
    beat(1, 1, memf(1), 2'b00, 1, 4'd5, 0);
    @(negedge clk);
    chk("single_back_idle", ar_ready, 1);
    chk("single_no_rvalid", r_valid, 0);
    @(posedge clk); #1;

    // INCR 4 beats
    send_ar(4'd3, 64'h1_0010, 8'd3, 3'd3, 2'b01);
    beat(1, 2, memf(2), 2'b00, 0, 4'd3, 0);
    beat(1, 3, memf(3), 2'b00, 0, 4'd3, 0);
    beat(1, 4, memf(4), 2'b00, 0, 4'd3, 0);
    beat(1, 5, memf(5), 2'b00, 1, 4'd3, 0);

    // WRAP 4 beats
    send_ar(4'd9, 64'h1_0018, 8'd3, 3'd3, 2'b10);
    beat(1, 3, memf(3), 2'b00, 0, 4'd9, 0);
    beat(1, 0, memf(0), 2'b00, 0, 4'd9, 0);
    beat(1, 1, memf(1), 2'b00, 0, 4'd9, 0);
    beat(1, 2, memf(2), 2'b00, 1, 4'd9, 0);

    // FIXED burst repeats the same word
    send_ar(4'd1, 64'h1_0040, 8'd1, 3'd3, 2'b00);
    beat(1, 8, memf(8), 2'b00, 0, 4'd1, 0);
    beat(1, 8, memf(8), 2'b00, 1, 4'd1, 0);

    // narrow INCR: size 2 from 0x1_0004 -> 0x1_0008
    send_ar(4'd2, 64'h1_0004, 8'd1, 3'd2, 2'b01);
    beat(1, 0, memf(0), 2'b00, 0, 4'd2, 0);
    beat(1, 1, memf(1), 2'b00, 1, 4'd2, 0);

    // running off the region end
    send_ar(4'd7, 64'h1_FFF8, 8'd1, 3'd3, 2'b01);
    beat(1, 13'h1FFF, memf(13'h1FFF), 2'b00, 0, 4'd7, 0);
    beat(0, 0, 64'h0, 2'b10, 1, 4'd7, 0);

    // backpressure on beat 1
    send_ar(4'd4, 64'h1_0020, 8'd2, 3'd3, 2'b01);
    beat(1, 4, memf(4), 2'b00, 0, 4'd4, 0);
    beat(1, 5, memf(5), 2'b00, 0, 4'd4, 5);
    beat(1, 6, memf(6), 2'b00, 1, 4'd4, 0);

    // illegal size
    send_ar(4'd6, 64'h1_0000, 8'd2, 3'd4, 2'b01);
    beat(0, 0, 64'h0, 2'b10, 0, 4'd6, 0);
    beat(0, 0, 64'h0, 2'b10, 0, 4'd6, 0);
    beat(0, 0, 64'h0, 2'b10, 1, 4'd6, 0);

    // reserved burst type
    send_ar(4'd8, 64'h1_0000, 8'd0, 3'd3, 2'b11);
    beat(0, 0, 64'h0, 2'b10, 1, 4'd8, 0);

    // WRAP with illegal length 2
    send_ar(4'd10, 64'h1_0000, 8'd2, 3'd3, 2'b10);
    beat(0, 0, 64'h0, 2'b10, 0, 4'd10, 0);
    beat(0, 0, 64'h0, 2'b10, 0, 4'd10, 0);
    beat(0, 0, 64'h0, 2'b10, 1, 4'd10, 0);

    // reset while a beat is presented, ready also high
    send_ar(4'd11, 64'h1_0000, 8'd3, 3'd3, 2'b01);
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_rvalid", r_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rvalid", r_valid, 0);
    chk("post_rst_arready", ar_ready, 1);
    chk("post_rst_req", mem_req, 0);
    @(posedge clk); @(negedge clk);
    chk("post_rst_rvalid2", r_valid, 0);
    chk("post_rst_req2", mem_req, 0);
    @(posedge clk); #1;

    // fresh burst after reset
    send_ar(4'd12, 64'h1_0030, 8'd0, 3'd3, 2'b01);
    beat(1, 6, memf(6), 2'b00, 1, 4'd12, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
